// File: rtl/fir_pkg.sv
// Shared FIR definitions: sequencer state encoding and default geometry,
// used by the MAC sequencer and the coefficient loader.
package fir_pkg;

  // Default filter geometry; 2**FIR_ADDR_W must cover FIR_NTAPS.
  localparam int FIR_NTAPS  = 62;
  localparam int FIR_ADDR_W = 7;

  // MAC sequencer states. Unused 3-bit codes fall back to IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } fir_seq_state_t;

endpackage

// File: rtl/fir_tap_addr_gen.sv
// Tap address generator: owns the delay-line write pointer and the tap index k.
// Produces the circularly wrapped sample address wr_ptr-k (mod NTAPS).
module fir_tap_addr_gen
  import fir_pkg::*;
#(
  parameter int NTAPS  = FIR_NTAPS,
  parameter int ADDR_W = FIR_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance_ptr,
  input  logic              clr_k,
  input  logic              inc_k,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] k,
  output logic [ADDR_W-1:0] tap_addr,
  output logic              last_tap
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NTAPS - 1);
  localparam logic [ADDR_W:0]   NTAPS_W  = (ADDR_W + 1)'(NTAPS);

  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] k_reg;
  logic [ADDR_W:0]   wrap_sum;

  // Pointer and tap index registers; both wrap at NTAPS-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      k_reg      <= '0;
    end else begin
      if (advance_ptr) begin
        wr_ptr_reg <= (wr_ptr_reg == LAST_IDX) ? '0 : wr_ptr_reg + ADDR_W'(1);
      end
      if (clr_k) begin
        k_reg <= '0;
      end else if (inc_k) begin
        k_reg <= (k_reg == LAST_IDX) ? '0 : k_reg + ADDR_W'(1);
      end
    end
  end

  // Wrapped sample address; the extra bit keeps wr_ptr+NTAPS from overflowing.
  always_comb begin
    wrap_sum = {1'b0, wr_ptr_reg} + NTAPS_W - {1'b0, k_reg};
    if (wr_ptr_reg >= k_reg) begin
      tap_addr = wr_ptr_reg - k_reg;
    end else if (wrap_sum[ADDR_W]) begin
      // Unreachable for legal parameters; clamp rather than alias.
      tap_addr = '0;
    end else begin
      tap_addr = wrap_sum[ADDR_W-1:0];
    end
  end

  assign wr_ptr   = wr_ptr_reg;
  assign k        = k_reg;
  assign last_tap = (k_reg == LAST_IDX);

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR MAC sequencer: writes each accepted sample into the circular delay line,
// walks all taps driving RAM addresses and MAC controls, then flags y[n].
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS  = FIR_NTAPS,
  parameter int ADDR_W = FIR_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coef_ready,
  input  logic              sample_valid,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [ADDR_W-1:0] smp_addr,
  output logic              smp_we,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              out_valid,
  output logic              busy,
  output logic              sample_drop
);

  fir_seq_state_t state_reg, state_next;
  logic           mac_en_reg;
  logic           sample_drop_reg;

  logic              advance_ptr, clr_k, inc_k, last_tap;
  logic [ADDR_W-1:0] wr_ptr, k, tap_addr;

  fir_tap_addr_gen #(
    .NTAPS  (NTAPS),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .advance_ptr (advance_ptr),
    .clr_k       (clr_k),
    .inc_k       (inc_k),
    .wr_ptr      (wr_ptr),
    .k           (k),
    .tap_addr    (tap_addr),
    .last_tap    (last_tap)
  );

  // State register plus the two registered strobes (MAC enable trails MAC by one cycle
  // to line up with RAM read data; drop flags any sample not accepted from IDLE).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      mac_en_reg      <= 1'b0;
      sample_drop_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      mac_en_reg      <= (state_reg == MAC);
      sample_drop_reg <= sample_valid && !((state_reg == IDLE) && coef_ready);
    end
  end

  // Next-state logic; unknown encodings recover to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sample_valid && coef_ready) state_next = WRITE;
      WRITE:   state_next = MAC;
      MAC:     if (last_tap) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore output decode and address-generator controls from the current state.
  always_comb begin
    coef_addr   = '0;
    smp_addr    = '0;
    smp_we      = 1'b0;
    mac_clr     = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    advance_ptr = 1'b0;
    clr_k       = 1'b0;
    inc_k       = 1'b0;
    case (state_reg)
      WRITE: begin
        busy     = 1'b1;
        smp_we   = 1'b1;
        smp_addr = wr_ptr;
        mac_clr  = 1'b1;
        clr_k    = 1'b1;
      end
      MAC: begin
        busy      = 1'b1;
        coef_addr = k;
        smp_addr  = tap_addr;
        inc_k     = 1'b1;
      end
      DRAIN: begin
        busy = 1'b1;
      end
      DONE: begin
        busy        = 1'b1;
        out_valid   = 1'b1;
        advance_ptr = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign mac_en      = mac_en_reg;
  assign sample_drop = sample_drop_reg;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: a 62-tap instance and a 4-tap instance.
// Stimulus pushes expected writes/outputs/drops; one monitor pops and compares.
module tb_fir_mac_sequencer;

  localparam int N0 = 62;
  localparam int N1 = 4;

  typedef struct {
    int dut;
    int wr;
    int t_we;
    int t_out;
  } exp_t;

  typedef struct {
    int dut;
    int t;
    bit busy;
  } drop_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a [2];
  logic cr_a  [2];
  logic sv_a  [2];

  logic [6:0] coef0, smp0;
  logic [1:0] coef1, smp1;
  logic [7:0] coef_a [2];
  logic [7:0] smp_a  [2];
  logic we_a [2], clr_a [2], en_a [2], ov_a [2], busy_a [2], drop_a [2];

  assign coef_a[0] = {1'b0, coef0};
  assign smp_a[0]  = {1'b0, smp0};
  assign coef_a[1] = {6'b0, coef1};
  assign smp_a[1]  = {6'b0, smp1};

  fir_mac_sequencer #(.NTAPS(N0), .ADDR_W(7)) dut0 (
    .clk(clk), .reset(rst_a[0]), .coef_ready(cr_a[0]), .sample_valid(sv_a[0]),
    .coef_addr(coef0), .smp_addr(smp0), .smp_we(we_a[0]), .mac_clr(clr_a[0]),
    .mac_en(en_a[0]), .out_valid(ov_a[0]), .busy(busy_a[0]), .sample_drop(drop_a[0])
  );

  fir_mac_sequencer #(.NTAPS(N1), .ADDR_W(2)) dut1 (
    .clk(clk), .reset(rst_a[1]), .coef_ready(cr_a[1]), .sample_valid(sv_a[1]),
    .coef_addr(coef1), .smp_addr(smp1), .smp_we(we_a[1]), .mac_clr(clr_a[1]),
    .mac_en(en_a[1]), .out_valid(ov_a[1]), .busy(busy_a[1]), .sample_drop(drop_a[1])
  );

  exp_t  exp_q  [$];
  drop_t drop_q [$];
  int    wrm      [2] = '{0, 0};
  int    last_acc [2] = '{0, 0};
  bit    done = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int ntaps(input int d);
    return (d == 0) ? N0 : N1;
  endfunction

  task automatic check(input bit ok, input string name, input int d,
                       input longint act_v, input longint exp_v);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, d, cyc, act_v, exp_v);
  endtask

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Pulse sample_valid for one cycle and record what the DUT must do with it.
  task automatic send(input int d, input bit accept, input bit busy_after);
    int n = ntaps(d);
    sv_a[d] = 1'b1;
    if (accept) begin
      exp_q.push_back(exp_t'{d, wrm[d], cyc + 1, cyc + n + 3});
      wrm[d]      = (wrm[d] + 1) % n;
      last_acc[d] = cyc;
    end else begin
      drop_q.push_back(drop_t'{d, cyc + 1, busy_after});
    end
    step();
    sv_a[d] = 1'b0;
  endtask

  initial begin
    int ca;
    rst_a = '{1'b1, 1'b1};
    cr_a  = '{1'b0, 1'b0};
    sv_a  = '{1'b0, 1'b0};
    repeat (3) step();
    rst_a = '{1'b0, 1'b0};
    step();
    step();

    // Sample while coefficients not loaded: dropped, sequencer stays idle.
    send(0, 1'b0, 1'b0);
    step();
    step();

    // 63 samples at minimum spacing: full delay-line wrap back to address 0.
    cr_a[0] = 1'b1;
    step();
    send(0, 1'b1, 1'b0);
    for (int i = 1; i <= 62; i++) begin
      wait_until(last_acc[0] + N0 + 4);
      send(0, 1'b1, 1'b0);
      if (i == 2) begin
        ca = last_acc[0];
        wait_until(ca + 10);
        send(0, 1'b0, 1'b1);          // during MAC
        wait_until(ca + N0 + 3);
        send(0, 1'b0, 1'b0);          // during DONE
      end
    end

    // coef_ready falls mid-sample: that sample completes, the next is dropped.
    wait_until(last_acc[0] + N0 + 4);
    send(0, 1'b1, 1'b0);
    ca = last_acc[0];
    wait_until(ca + 5);
    cr_a[0] = 1'b0;
    wait_until(ca + N0 + 4);
    send(0, 1'b0, 1'b0);
    cr_a[0] = 1'b1;

    // Reset during MAC at k=30 aborts the sample and rewinds the write pointer.
    step();
    send(0, 1'b1, 1'b0);
    ca = last_acc[0];
    wait_until(ca + 32);
    rst_a[0] = 1'b1;
    step();
    rst_a[0] = 1'b0;
    wrm[0] = 0;
    step();
    step();
    send(0, 1'b1, 1'b0);
    wait_until(last_acc[0] + N0 + 6);

    // Small instance: several wraps, one drop in MAC.
    cr_a[1] = 1'b1;
    step();
    send(1, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      wait_until(last_acc[1] + N1 + 4);
      send(1, 1'b1, 1'b0);
      if (i == 3) begin
        ca = last_acc[1];
        wait_until(ca + 3);
        send(1, 1'b0, 1'b1);
      end
    end
    wait_until(last_acc[1] + N1 + 6);
    done = 1'b1;
  end

  // ---------------- monitor ----------------
  bit         act       [2] = '{0, 0};
  bit         prev_rst  [2] = '{0, 0};
  int         tap_idx   [2] = '{0, 0};
  int         tap_err   [2] = '{0, 0};
  int         range_err [2] = '{0, 0};
  logic [7:0] prev_coef [2];
  logic [7:0] prev_smp  [2];

  always @(negedge clk) begin
    int n;
    int exp_s;
    logic [21:0] outs;
    for (int d = 0; d < 2; d++) begin
      n = ntaps(d);
      outs = {coef_a[d], smp_a[d], we_a[d], clr_a[d], en_a[d], ov_a[d], busy_a[d], drop_a[d]};
      if (prev_rst[d]) begin
        check(outs == 22'd0, "outputs_after_reset", d, longint'(outs), 0);
      end
      if (rst_a[d]) begin
        if (act[d] && exp_q.size() > 0) begin
          $display("dut%0d sample wr_ptr=%0d aborted by reset at cycle %0d", d, exp_q[0].wr, cyc);
          void'(exp_q.pop_front());
        end
        act[d] = 1'b0;
      end else begin
        if (smp_a[d] >= 8'(n)) range_err[d]++;
        if (we_a[d]) begin
          if (!act[d] && exp_q.size() > 0 && exp_q[0].dut == d) begin
            check(smp_a[d] == 8'(exp_q[0].wr), "write_addr", d, smp_a[d], exp_q[0].wr);
            check(cyc == exp_q[0].t_we, "write_cycle", d, cyc, exp_q[0].t_we);
            check(clr_a[d] == 1'b1, "mac_clr_with_write", d, clr_a[d], 1);
            act[d] = 1'b1;
            tap_idx[d] = 0;
            tap_err[d] = 0;
          end else begin
            check(1'b0, "unexpected_smp_we", d, 1, 0);
          end
        end
        if (en_a[d]) begin
          if (act[d] && tap_idx[d] < n) begin
            exp_s = (exp_q[0].wr + n - tap_idx[d]) % n;
            if (prev_coef[d] != 8'(tap_idx[d]) || prev_smp[d] != 8'(exp_s)) begin
              if (tap_err[d] == 0)
                $display("dut%0d tap %0d addr coef=%0d smp=%0d, want coef=%0d smp=%0d",
                         d, tap_idx[d], prev_coef[d], prev_smp[d], tap_idx[d], exp_s);
              tap_err[d]++;
            end
            tap_idx[d]++;
          end else if (act[d]) begin
            tap_idx[d]++;
          end else begin
            check(1'b0, "stray_mac_en", d, 1, 0);
          end
        end
        if (ov_a[d]) begin
          if (act[d]) begin
            check(cyc == exp_q[0].t_out, "out_valid_cycle", d, cyc, exp_q[0].t_out);
            check(tap_idx[d] == n, "mac_en_count", d, tap_idx[d], n);
            check(tap_err[d] == 0, "tap_addr_sequence", d, tap_err[d], 0);
            check(range_err[d] == 0, "smp_addr_range", d, range_err[d], 0);
            $display("dut%0d sample wr_ptr=%0d out_valid at cycle %0d", d, exp_q[0].wr, cyc);
            void'(exp_q.pop_front());
            act[d] = 1'b0;
          end else begin
            check(1'b0, "unexpected_out_valid", d, 1, 0);
          end
        end
        if (drop_a[d]) begin
          if (drop_q.size() > 0 && drop_q[0].dut == d) begin
            check(cyc == drop_q[0].t, "drop_cycle", d, cyc, drop_q[0].t);
            check(busy_a[d] == drop_q[0].busy, "busy_at_drop", d, busy_a[d], drop_q[0].busy);
            $display("dut%0d sample_drop at cycle %0d busy=%0d", d, cyc, busy_a[d]);
            void'(drop_q.pop_front());
          end else begin
            check(1'b0, "unexpected_sample_drop", d, 1, 0);
          end
        end
      end
      prev_rst[d]  = rst_a[d];
      prev_coef[d] = coef_a[d];
      prev_smp[d]  = smp_a[d];
    end

    if (done || cyc > 30000) begin
      check(!(cyc > 30000) || done, "timeout", 0, cyc, 30000);
      check(exp_q.size() == 0, "pending_outputs", 0, exp_q.size(), 0);
      check(drop_q.size() == 0, "pending_drops", 0, drop_q.size(), 0);
      check(range_err[0] + range_err[1] == 0, "smp_addr_range_total", 0,
            range_err[0] + range_err[1], 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  end

endmodule
